// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: one handshaked memory transaction per load/store, pipeline stall until done.
// Optional feature macro MEM_TIMEOUT_EN: bounds REQ+WAIT to TIMEOUT cycles, then faults to ERR.
module mem_access_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WriteData,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_busy,
    input  logic              mem_done,
    input  logic              mem_err,
    output logic              Stall,
    output logic [DATA_W-1:0] ReadData,
    output logic              ReadValid,
    output logic              Err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_RESP = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t            state_r;
    state_t            next_s;
    logic              req_s;
    logic              bad_s;
    logic              stall_s;
    logic              rd_op_s;
    logic              timeout_s;
    logic              op_rd_r;
    logic              mem_rd_r;
    logic              mem_wr_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] read_data_r;
    logic              read_valid_r;
    logic              err_r;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_r;

    // Transaction age counter: restarts on each new request, runs while REQ/WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == S_IDLE && next_s == S_REQ) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == S_REQ || state_r == S_WAIT) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Fires in the cycle whose closing edge would bring the count to TIMEOUT
    assign timeout_s = (cnt_r == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Request decode, next-state logic and combinational stall
    always_comb begin
        req_s   = (MemRead ^ MemWrite) & ~Addr[0];
        bad_s   = (MemRead & MemWrite) | ((MemRead | MemWrite) & Addr[0]);
        rd_op_s = (state_r == S_IDLE) ? MemRead : op_rd_r;
        next_s  = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_s)      next_s = S_REQ;
                else if (bad_s) next_s = S_ERR;
                else            next_s = S_IDLE;
            end
            S_REQ: begin
                // err beats done; done beats the timeout limit
                if (mem_err)        next_s = S_ERR;
                else if (mem_done)  next_s = S_RESP;
                else if (timeout_s) next_s = S_ERR;
                else if (mem_busy)  next_s = S_REQ;
                else                next_s = S_WAIT;
            end
            S_WAIT: begin
                if (mem_err)        next_s = S_ERR;
                else if (mem_done)  next_s = S_RESP;
                else if (timeout_s) next_s = S_ERR;
                else                next_s = S_WAIT;
            end
            S_RESP:  next_s = S_IDLE;
            S_ERR:   next_s = S_ERR;
            default: next_s = S_IDLE;
        endcase
        stall_s = ((state_r == S_IDLE) & req_s) | (state_r == S_REQ) |
                  (state_r == S_WAIT) | (state_r == S_ERR);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= S_IDLE;
        else        state_r <= next_s;
    end

    // Capture the instruction's address, store data and op when it is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            op_rd_r     <= 1'b0;
        end else if (state_r == S_IDLE && req_s) begin
            mem_addr_r  <= Addr;
            mem_wdata_r <= WriteData;
            op_rd_r     <= MemRead;
        end else begin
            mem_addr_r  <= mem_addr_r;
            mem_wdata_r <= mem_wdata_r;
            op_rd_r     <= op_rd_r;
        end
    end

    // Registered enables and status, decoded from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_r     <= 1'b0;
            mem_wr_r     <= 1'b0;
            read_valid_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            mem_rd_r     <= (next_s == S_REQ) &  rd_op_s;
            mem_wr_r     <= (next_s == S_REQ) & ~rd_op_s;
            read_valid_r <= (next_s == S_RESP) & op_rd_r;
            err_r        <= (next_s == S_ERR);
        end
    end

    // Load data is taken only on a successful load completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   read_data_r <= {DATA_W{1'b0}};
        else if ((next_s == S_RESP) && op_rd_r)       read_data_r <= mem_rdata;
        else                                          read_data_r <= read_data_r;
    end

    assign mem_rd    = mem_rd_r;
    assign mem_wr    = mem_wr_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign Stall     = stall_s;
    assign ReadData  = read_data_r;
    assign ReadValid = read_valid_r;
    assign Err       = err_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus queues expected enables/load data, a negedge monitor checks them.
// Timeout scenario follows MEM_TIMEOUT_EN (TIMEOUT=8).
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [15:0] Addr = 16'h0000;
    logic [15:0] WriteData = 16'h0000;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_busy = 1'b0;
    logic        mem_done = 1'b0;
    logic        mem_err = 1'b0;
    logic        Stall;
    logic [15:0] ReadData;
    logic        ReadValid;
    logic        Err;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

    req_t        exp_req[$];
    logic [15:0] exp_rd[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          stall_cnt = 0;

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .Addr(Addr), .WriteData(WriteData), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_busy(mem_busy), .mem_done(mem_done), .mem_err(mem_err),
        .Stall(Stall), .ReadData(ReadData), .ReadValid(ReadValid), .Err(Err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic rd, input logic [15:0] a, input logic [15:0] wd);
        req_t r;
        r.rd = rd; r.wr = ~rd; r.addr = a; r.wdata = wd;
        exp_req.push_back(r);
    endtask

    task automatic do_reset();
        MemRead = 1'b0; MemWrite = 1'b0; mem_done = 1'b0; mem_err = 1'b0; mem_busy = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Monitor: every enable cycle and every ReadValid pulse consumes one expected entry
    always @(negedge clk) begin
        if (rst_n) begin
            if (Stall) stall_cnt++;
            if (mem_rd || mem_wr) begin
                if (exp_req.size() == 0) begin
                    check("unexpected_enable", {62'd0, mem_rd, mem_wr}, 64'd0);
                end else begin
                    req_t r;
                    r = exp_req.pop_front();
                    check("req_enables", {62'd0, mem_rd, mem_wr}, {62'd0, r.rd, r.wr});
                    check("req_addr", {48'd0, mem_addr}, {48'd0, r.addr});
                    check("req_wdata", {48'd0, mem_wdata}, {48'd0, r.wdata});
                end
            end
            if (ReadValid) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_readvalid", {63'd0, ReadValid}, 64'd0);
                end else begin
                    logic [15:0] d;
                    d = exp_rd.pop_front();
                    check("read_data", {48'd0, ReadData}, {48'd0, d});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        #2;
        check("reset_outputs", {mem_rd, mem_wr, mem_addr, mem_wdata, Stall, ReadData, ReadValid, Err}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Zero-wait load followed back-to-back by a zero-wait store
        stall_cnt = 0;
        MemRead = 1'b1; Addr = 16'h0010; WriteData = 16'h5555;
        push_req(1'b1, 16'h0010, 16'h5555);
        exp_rd.push_back(16'hBEEF);
        @(negedge clk) check("stall_idle_request", {63'd0, Stall}, 64'd1);
        tick();
        mem_done = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_done = 1'b0;
        @(negedge clk) check("stall_in_resp", {63'd0, Stall}, 64'd0);
        tick();
        MemRead = 1'b0; MemWrite = 1'b1; Addr = 16'h0012; WriteData = 16'hCAFE;
        push_req(1'b0, 16'h0012, 16'hCAFE);
        tick();
        mem_done = 1'b1; mem_rdata = 16'h1111;
        tick();
        mem_done = 1'b0;
        tick();
        MemWrite = 1'b0;
        tick();
        check("b2b_stall_cycles", stall_cnt, 64'd4);
        check("readdata_after_store", {48'd0, ReadData}, 64'hBEEF);

        // Store: busy 2 cycles, then 3 WAIT cycles before done
        stall_cnt = 0;
        MemWrite = 1'b1; Addr = 16'h0020; WriteData = 16'h1234;
        for (int i = 0; i < 3; i++) push_req(1'b0, 16'h0020, 16'h1234);
        tick(); mem_busy = 1'b1;
        tick(); mem_busy = 1'b1;
        tick(); mem_busy = 1'b0;
        tick();
        tick();
        tick(); mem_done = 1'b1; mem_rdata = 16'h9999;
        tick(); mem_done = 1'b0;
        @(negedge clk) check("store_resp_stall", {63'd0, Stall}, 64'd0);
        tick(); MemWrite = 1'b0;
        tick();
        check("store_stall_cycles", stall_cnt, 64'd7);
        check("store_keeps_readdata", {48'd0, ReadData}, 64'hBEEF);

        // Misaligned load -> ERR, held until reset
        MemRead = 1'b1; Addr = 16'h0003;
        @(negedge clk) check("misaligned_no_stall_idle", {63'd0, Stall}, 64'd0);
        tick();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk) check("err_hold", {62'd0, Err, Stall}, 64'd3);
            tick();
        end
        MemRead = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", {mem_rd, mem_wr, mem_addr, mem_wdata, Stall, ReadData, ReadValid, Err}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Read and write together -> ERR with no enable
        MemRead = 1'b1; MemWrite = 1'b1; Addr = 16'h0040;
        tick();
        @(negedge clk) check("rw_both_err", {62'd0, Err, Stall}, 64'd3);
        tick();
        do_reset();

        // mem_err and mem_done together in WAIT -> ERR, load data not taken
        MemRead = 1'b1; Addr = 16'h0050; WriteData = 16'h0000;
        push_req(1'b1, 16'h0050, 16'h0000);
        tick();
        tick(); mem_err = 1'b1; mem_done = 1'b1; mem_rdata = 16'hDEAD;
        tick(); mem_err = 1'b0; mem_done = 1'b0;
        @(negedge clk) check("err_beats_done", {62'd0, Err, Stall}, 64'd3);
        check("err_no_readdata", {48'd0, ReadData}, 64'd0);
        tick();
        do_reset();

        // Reset mid-WAIT; stray done afterwards is ignored
        MemRead = 1'b1; Addr = 16'h0060;
        push_req(1'b1, 16'h0060, 16'h0000);
        tick();
        tick();
        @(negedge clk) check("wait_stall", {63'd0, Stall}, 64'd1);
        #1;
        rst_n = 1'b0; MemRead = 1'b0;
        #1;
        check("midwait_reset", {61'd0, mem_rd, Stall, Err}, 64'd0);
        tick();
        rst_n = 1'b1;
        mem_done = 1'b1; mem_rdata = 16'h7777;
        tick(); mem_done = 1'b0;
        tick();
        check("stray_done_ignored", {47'd0, Stall, ReadData}, 64'd0);

        // Unresponsive memory
        MemRead = 1'b1; Addr = 16'h0070;
        push_req(1'b1, 16'h0070, 16'h0000);
        tick();
`ifdef MEM_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk) check("timeout_not_yet", {63'd0, Err}, 64'd0);
            tick();
        end
        @(negedge clk) check("timeout_err", {62'd0, Err, Stall}, 64'd3);
`else
        for (int i = 0; i < 100; i++) tick();
        @(negedge clk) check("no_timeout_wait", {62'd0, Err, Stall}, 64'd1);
`endif
        tick();
        do_reset();

        check("req_queue_drained", exp_req.size(), 64'd0);
        check("rd_queue_drained", exp_rd.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
